tinker_mem_arbiter: RTL and testbench

TINKER_MEM_ARBITER -- requirements
Module: tinker_mem_arbiter

---
 rtl/tinker_pkg.sv | 23 ++
 rtl/tinker_arb_timer.sv | 30 +++
 rtl/tinker_mem_arbiter.sv | 166 ++++++++++++++++
 tb/tb_tinker_mem_arbiter.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tinker_pkg.sv
// Shared types and constants for the tinker core: arbiter FSM states, port ids, reset PC and stack top.
package tinker_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_RSP = 2'd2
    } arb_state_e;

    typedef enum logic {
        PORT_FETCH = 1'b0,
        PORT_DATA  = 1'b1
    } port_e;

    localparam logic [63:0] RESET_PC  = 64'h2000;
    localparam logic [63:0] STACK_TOP = 64'd524288;

    // Round-robin choice under contention: whichever port did not win last time.
    function automatic port_e rr_pick(input port_e last_port);
        return (last_port == PORT_FETCH) ? PORT_DATA : PORT_FETCH;
    endfunction

endpackage

// File: rtl/tinker_arb_timer.sv
// Transaction watchdog for the memory arbiter: counts enabled cycles, flags when TIMEOUT_CYC is reached.
module tinker_arb_timer #(
    parameter int TIMEOUT_CYC = 256
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int               CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYC);

    logic [CNT_W-1:0] r_count;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable && (r_count != LIMIT)) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign expired = enable && (r_count == LIMIT);

endmodule

// File: rtl/tinker_mem_arbiter.sv
// Two-port (fetch/data) arbiter onto a single-outstanding memory port with timeout abort.
// Define TINKER_ARB_RR_EN for round-robin contention; default is fixed data-over-fetch priority.
module tinker_mem_arbiter
    import tinker_pkg::*;
#(
    parameter int ADDR_W      = 64,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic              clk,
    input  logic              reset,
    // fetch port
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_gnt,
    output logic              f_rvalid,
    output logic [31:0]       f_rdata,
    // data port
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [63:0]       d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [63:0]       d_rdata,
    // memory side
    output logic              m_req,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [63:0]       m_wdata,
    input  logic              m_ready,
    input  logic              m_rvalid,
    input  logic [63:0]       m_rdata,
    output logic              arb_err
);

    arb_state_e        r_state;
    arb_state_e        w_state_nxt;
    port_e             r_port;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [63:0]       r_wdata;
    logic              r_arb_err;

    port_e             w_winner;
    logic              w_grant;
    logic              w_expired;
    logic              w_done;
    logic              w_issue;

    // NOTE: every output is qualified by reset, so a request held during reset cannot leak a grant.
    assign w_grant = !reset && (r_state == IDLE) && (d_req || f_req);

`ifdef TINKER_ARB_RR_EN
    port_e r_last_port;

    always_comb begin
        if (d_req && f_req) begin
            w_winner = rr_pick(r_last_port);
        end else if (d_req) begin
            w_winner = PORT_DATA;
        end else begin
            w_winner = PORT_FETCH;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last_port <= PORT_FETCH;
        end else if (w_grant) begin
            r_last_port <= w_winner;
        end
    end
`else
    always_comb begin
        w_winner = d_req ? PORT_DATA : PORT_FETCH;
    end
`endif

    tinker_arb_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (r_state == IDLE),
        .enable  (r_state != IDLE),
        .expired (w_expired)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_arb_err <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_expired) begin
                r_arb_err <= 1'b1;
            end
        end
    end

    // Request fields are captured once at grant; later input changes cannot disturb the transaction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_port  <= PORT_FETCH;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_grant) begin
            r_port <= w_winner;
            if (w_winner == PORT_DATA) begin
                r_we    <= d_we;
                r_addr  <= d_addr;
                r_wdata <= d_wdata;
            end else begin
                r_we    <= 1'b0;
                r_addr  <= f_addr;
                r_wdata <= '0;
            end
        end
    end

    // NOTE: combinational blocks assign defaults first so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (d_req || f_req) begin
                    w_state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (w_expired) begin
                    w_state_nxt = IDLE;
                end else if (m_ready) begin
                    w_state_nxt = WAIT_RSP;
                end
            end
            WAIT_RSP: begin
                if (w_expired || m_rvalid) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // A timeout takes precedence over a coincident response and returns zero data.
    assign w_done  = !reset && (w_expired || ((r_state == WAIT_RSP) && m_rvalid));
    assign w_issue = !reset && (r_state == ISSUE) && !w_expired;

    assign f_gnt    = w_grant && (w_winner == PORT_FETCH);
    assign d_gnt    = w_grant && (w_winner == PORT_DATA);

    assign f_rvalid = w_done && (r_port == PORT_FETCH);
    assign d_rvalid = w_done && (r_port == PORT_DATA);
    assign f_rdata  = (f_rvalid && !w_expired) ? m_rdata[31:0] : 32'd0;
    assign d_rdata  = (d_rvalid && !w_expired && !r_we) ? m_rdata : 64'd0;

    assign m_req    = w_issue;
    assign m_we     = w_issue && r_we;
    assign m_addr   = w_issue ? r_addr : '0;
    assign m_wdata  = w_issue ? r_wdata : 64'd0;

    assign arb_err  = !reset && r_arb_err;

endmodule

// File: tb/tb_tinker_mem_arbiter.sv
// Directed self-checking bench for tinker_mem_arbiter (TIMEOUT_CYC=8); the memory side is driven by hand.
module tb_tinker_mem_arbiter;

    localparam int ADDR_W      = 64;
    localparam int TIMEOUT_CYC = 8;

    logic              clk;
    logic              reset;
    logic              f_req;
    logic [ADDR_W-1:0] f_addr;
    logic              f_gnt;
    logic              f_rvalid;
    logic [31:0]       f_rdata;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [63:0]       d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [63:0]       d_rdata;
    logic              m_req;
    logic              m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [63:0]       m_wdata;
    logic              m_ready;
    logic              m_rvalid;
    logic [63:0]       m_rdata;
    logic              arb_err;

    int n_checks = 0;
    int n_fail   = 0;

    tinker_mem_arbiter #(
        .ADDR_W      (ADDR_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .f_req    (f_req),
        .f_addr   (f_addr),
        .f_gnt    (f_gnt),
        .f_rvalid (f_rvalid),
        .f_rdata  (f_rdata),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_gnt    (d_gnt),
        .d_rvalid (d_rvalid),
        .d_rdata  (d_rdata),
        .m_req    (m_req),
        .m_we     (m_we),
        .m_addr   (m_addr),
        .m_wdata  (m_wdata),
        .m_ready  (m_ready),
        .m_rvalid (m_rvalid),
        .m_rdata  (m_rdata),
        .arb_err  (arb_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench did not complete");
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs are driven here.
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    // Let combinational outputs settle before sampling.
    task automatic settle();
        #1;
    endtask

    logic exp_d [4];

    initial begin
        reset    = 1'b1;
        f_req    = 1'b1;
        f_addr   = '0;
        d_req    = 1'b0;
        d_we     = 1'b0;
        d_addr   = '0;
        d_wdata  = '0;
        m_ready  = 1'b0;
        m_rvalid = 1'b1;
        m_rdata  = 64'hFFFF_FFFF_FFFF_FFFF;

        // Reset holds everything at zero even with a request and a response pending.
        cyc(); cyc(); settle();
        check("rst_f_gnt",    f_gnt,    0);
        check("rst_f_rvalid", f_rvalid, 0);
        check("rst_m_req",    m_req,    0);
        check("rst_m_addr",   m_addr,   0);
        check("rst_arb_err",  arb_err,  0);

        // Fetch of the reset PC.
        reset = 1'b0; m_rvalid = 1'b0; m_rdata = '0;
        f_addr = 64'h2000; m_ready = 1'b1;
        settle();
        check("f1_f_gnt", f_gnt, 1);
        check("f1_d_gnt", d_gnt, 0);
        cyc(); f_req = 1'b0; settle();
        check("f1_gnt_pulse", f_gnt, 0);
        check("f1_m_req",     m_req, 1);
        check("f1_m_addr",    m_addr, 64'h2000);
        check("f1_m_we",      m_we, 0);
        cyc(); settle();
        check("f1_wait_rvalid", f_rvalid, 0);
        check("f1_wait_m_req",  m_req, 0);
        check("f1_wait_m_addr", m_addr, 0);
        cyc(); m_rvalid = 1'b1; m_rdata = 64'h0000_0000_C840_0005; settle();
        check("f1_f_rvalid", f_rvalid, 1);
        check("f1_f_rdata",  f_rdata, 32'hC840_0005);
        check("f1_d_rvalid", d_rvalid, 0);
        check("f1_d_rdata",  d_rdata, 0);
        check("f1_d_gnt",    d_gnt, 0);
        cyc(); m_rvalid = 1'b0; m_rdata = '0; settle();
        check("f1_after_rvalid", f_rvalid, 0);
        check("f1_after_rdata",  f_rdata, 0);

        // Contention: store wins, fields are frozen at grant, fetch follows after one IDLE cycle.
        f_req = 1'b1; f_addr = 64'h3000;
        d_req = 1'b1; d_we = 1'b1; d_addr = 64'h7FFF8; d_wdata = 64'h2004;
        settle();
        check("st_d_gnt", d_gnt, 1);
        check("st_f_gnt", f_gnt, 0);
        cyc(); d_wdata = 64'hBEEF; d_addr = '0; d_we = 1'b0; settle();
        check("st_m_req",   m_req, 1);
        check("st_m_we",    m_we, 1);
        check("st_m_wdata", m_wdata, 64'h2004);
        check("st_m_addr",  m_addr, 64'h7FFF8);
        check("st_no_gnt",  {f_gnt, d_gnt}, 0);
        cyc(); m_rvalid = 1'b1; m_rdata = 64'h1111_2222_3333_4444; settle();
        check("st_d_rvalid", d_rvalid, 1);
        check("st_d_rdata",  d_rdata, 0);
        check("st_f_gnt_wait", f_gnt, 0);
        cyc(); m_rvalid = 1'b0; d_req = 1'b0; settle();
        check("st_then_f_gnt", f_gnt, 1);
        check("st_then_d_gnt", d_gnt, 0);
        cyc(); f_req = 1'b0; m_ready = 1'b0; settle();
        check("f2_m_addr",  m_addr, 64'h3000);
        check("f2_m_wdata", m_wdata, 0);
        check("f2_m_we",    m_we, 0);
        cyc(); m_ready = 1'b1; settle();
        check("f2_hold_m_req", m_req, 1);
        cyc(); m_rvalid = 1'b1; m_rdata = 64'hAABB_CCDD_1122_3344; settle();
        check("f2_f_rdata", f_rdata, 32'h1122_3344);
        cyc(); m_rvalid = 1'b0; settle();

        // Stray response in IDLE and ISSUE is ignored; load returns the full word.
        m_rvalid = 1'b1; settle();
        check("idle_ign_rvalid", {f_rvalid, d_rvalid}, 0);
        m_rvalid = 1'b0;
        d_req = 1'b1; d_we = 1'b0; d_addr = 64'h100; settle();
        check("ld_d_gnt", d_gnt, 1);
        cyc(); d_req = 1'b0; m_ready = 1'b0; m_rvalid = 1'b1; settle();
        check("issue_ign_rvalid", d_rvalid, 0);
        cyc(); m_ready = 1'b1; m_rvalid = 1'b0; settle();
        check("ld_m_we", m_we, 0);
        cyc(); m_rvalid = 1'b1; m_rdata = 64'h0123_4567_89AB_CDEF; settle();
        check("ld_d_rvalid", d_rvalid, 1);
        check("ld_d_rdata",  d_rdata, 64'h0123_4567_89AB_CDEF);
        cyc(); m_rvalid = 1'b0; settle();

        // A one-cycle data request during a fetch in WAIT_RSP is never granted.
        f_req = 1'b1; f_addr = 64'h4000; settle();
        check("pl_f_gnt", f_gnt, 1);
        cyc(); f_req = 1'b0; settle();
        cyc(); d_req = 1'b1; settle();
        check("pl_d_gnt_wait", d_gnt, 0);
        cyc(); d_req = 1'b0; m_rvalid = 1'b1; m_rdata = 64'h5; settle();
        check("pl_f_rvalid", f_rvalid, 1);
        cyc(); m_rvalid = 1'b0; settle();
        check("pl_d_gnt_idle", d_gnt, 0);
        cyc(); settle();
        check("pl_d_gnt_later", d_gnt, 0);

        // Both ports requesting continuously for four transactions.
`ifdef TINKER_ARB_RR_EN
        exp_d = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
        exp_d = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
        f_req = 1'b1; f_addr = 64'h5000;
        d_req = 1'b1; d_we = 1'b0; d_addr = 64'h6000;
        for (int i = 0; i < 4; i++) begin
            settle();
            check($sformatf("cont%0d_d_gnt", i), d_gnt, exp_d[i]);
            check($sformatf("cont%0d_f_gnt", i), f_gnt, !exp_d[i]);
            cyc(); settle();
            check($sformatf("cont%0d_m_addr", i), m_addr, exp_d[i] ? 64'h6000 : 64'h5000);
            cyc(); m_rvalid = 1'b1; m_rdata = 64'h9; settle();
            cyc(); m_rvalid = 1'b0;
        end
        f_req = 1'b0; d_req = 1'b0;

        // Timeout: memory accepts but never responds.
        f_req = 1'b1; f_addr = 64'h7000; settle();
        check("to_f_gnt", f_gnt, 1);
        cyc(); f_req = 1'b0; m_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        for (int k = 0; k < TIMEOUT_CYC; k++) begin
            settle();
            check($sformatf("to_quiet%0d", k), f_rvalid, 0);
            cyc();
        end
        settle();
        check("to_f_rvalid",   f_rvalid, 1);
        check("to_f_rdata",    f_rdata, 0);
        check("to_err_before", arb_err, 0);
        cyc(); settle();
        check("to_err_set",     arb_err, 1);
        check("to_rvalid_pulse", f_rvalid, 0);
        f_req = 1'b1; f_addr = 64'h7100; settle();
        check("to_next_gnt", f_gnt, 1);
        cyc(); f_req = 1'b0; settle();
        cyc(); m_rvalid = 1'b1; m_rdata = 64'h42; settle();
        check("to_next_rdata", f_rdata, 32'h42);
        check("to_err_sticky", arb_err, 1);
        cyc(); m_rvalid = 1'b0; settle();

        // Reset in WAIT_RSP drops the load; the response arriving under reset is lost.
        d_req = 1'b1; d_we = 1'b0; d_addr = 64'h8000; settle();
        check("rs_d_gnt", d_gnt, 1);
        cyc(); d_req = 1'b0; settle();
        cyc(); reset = 1'b1; m_rvalid = 1'b1; m_rdata = 64'h1234; settle();
        check("rs_d_rvalid", d_rvalid, 0);
        check("rs_d_rdata",  d_rdata, 0);
        check("rs_arb_err",  arb_err, 0);
        check("rs_m_req",    m_req, 0);
        cyc(); settle();
        check("rs_hold_rvalid", d_rvalid, 0);
        reset = 1'b0; settle();
        check("rs_idle_rvalid", {f_rvalid, d_rvalid}, 0);
        f_req = 1'b1; f_addr = 64'h9000; settle();
        check("rs_f_gnt", f_gnt, 1);
        cyc(); f_req = 1'b0; settle();
        check("rs_m_addr", m_addr, 64'h9000);
        cyc(); m_rvalid = 1'b1; m_rdata = 64'h77; settle();
        check("rs_f_rvalid", f_rvalid, 1);
        check("rs_f_rdata",  f_rdata, 32'h77);
        check("rs_err_clear", arb_err, 0);
        cyc(); m_rvalid = 1'b0; settle();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
